seq_adder_subtractor: RTL and testbench

Parametrised multi-cycle two's-complement adder/subtractor computing WIDTH-bit A±B in CHUNK-bit slices, one slice per clock, with the carry held in a register between slices. It generalises the 4-bit combinational ripple adder/subtractor to arbitrary width and adds a valid/ready handshake on both sides, signed-overflow and zero flags, and optional saturation. It sits between an operand producer and a result consumer in datapaths where a full-width carry chain would limit clock rate.

---
 rtl/seq_adder_subtractor.sv | 114 +++++++++++
 tb/tb_seq_adder_subtractor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_subtractor.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH-bit A +/- B in CHUNK-bit slices, one per clock.
// Optional feature: define SEQ_ADDSUB_SATURATE_EN to clamp overflowing results to the signed limit.
module seq_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef SEQ_ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = ({WIDTH{1'b1}} >> 1);
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, bx_reg, sum_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK:0]   slice_res;
  logic [WIDTH-1:0] sum_next, out_next;
  logic             ovf_next, last_slice;
  int               base;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Handshake outputs depend on the registered state only.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    base       = int'(cnt) * CHUNK;
    last_slice = (cnt == LAST);
    slice_res  = {1'b0, a_reg[base +: CHUNK]} + {1'b0, bx_reg[base +: CHUNK]}
               + {{CHUNK{1'b0}}, carry};
    sum_next   = sum_reg;
    sum_next[base +: CHUNK] = slice_res[CHUNK-1:0];
    ovf_next   = (a_reg[WIDTH-1] == bx_reg[WIDTH-1]) && (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
    out_next   = sum_next;
`ifdef SEQ_ADDSUB_SATURATE_EN
    if (ovf_next) out_next = a_reg[WIDTH-1] ? ~SAT_MAX : SAT_MAX;
`endif
  end

  // Operand registers need no reset: they are always loaded before CALC reads them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry <= 1'b0;
      cnt   <= '0;
      out   <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            bx_reg <= B ^ {WIDTH{mode}};
            carry  <= mode;
            cnt    <= '0;
          end
        end
        CALC: begin
          sum_reg <= sum_next;
          carry   <= slice_res[CHUNK];
          cnt     <= cnt + CW'(1);
          if (last_slice) begin
            out  <= out_next;
            Cout <= slice_res[CHUNK];
            ovf  <= ovf_next;
            zero <= (out_next == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_adder_subtractor.sv
// Self-checking bench: 16/4 instance driven from a vector table, plus exhaustive 4-bit sweeps
// (CHUNK=4 and CHUNK=1) against a behavioural model, with a queue scoreboard.
module tb_seq_adder_subtractor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv16, ir16, ov16, or16, m16, c16, f16, z16;
  logic [15:0] a16, b16, out16;
  logic        iv_p, ir_p, ov_p, or_p, m_p, c_p, f_p, z_p;
  logic [3:0]  a_p, b_p, out_p;
  logic        iv_s, ir_s, ov_s, or_s, m_s, c_s, f_s, z_s;
  logic [3:0]  a_s, b_s, out_s;

  seq_adder_subtractor #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16), .mode(m16),
    .out_valid(ov16), .out_ready(or16), .out(out16), .Cout(c16), .ovf(f16), .zero(z16));
  seq_adder_subtractor #(.WIDTH(4), .CHUNK(4)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_p), .in_ready(ir_p), .A(a_p), .B(b_p), .mode(m_p),
    .out_valid(ov_p), .out_ready(or_p), .out(out_p), .Cout(c_p), .ovf(f_p), .zero(z_p));
  seq_adder_subtractor #(.WIDTH(4), .CHUNK(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .A(a_s), .B(b_s), .mode(m_s),
    .out_valid(ov_s), .out_ready(or_s), .out(out_s), .Cout(c_s), .ovf(f_s), .zero(z_s));

  typedef struct { logic [15:0] out; logic cout; logic ovf; logic zero; } res_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic m; res_t exp; } vec_t;

  res_t sb[$];
  vec_t tbl[8];
  int   total = 0;
  int   bad = 0;

  function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, logic m);
    res_t r;
    logic [31:0] mask, ai, bx, full, sum;
    logic amsb, bmsb, smsb;
    mask = (32'd1 << w) - 32'd1;
    ai   = 32'(a) & mask;
    bx   = m ? ((~32'(b)) & mask) : (32'(b) & mask);
    full = ai + bx + 32'(m);
    sum  = full & mask;
    amsb = ai[w-1];
    bmsb = bx[w-1];
    smsb = sum[w-1];
    r.cout = full[w];
    r.ovf  = (amsb == bmsb) && (smsb != amsb);
`ifdef SEQ_ADDSUB_SATURATE_EN
    if (r.ovf) sum = amsb ? (32'd1 << (w - 1)) : (mask >> 1);
`endif
    r.out  = sum[15:0];
    r.zero = (sum == 32'd0);
    return r;
  endfunction

  function automatic res_t sample(int idx);
    res_t r;
    case (idx)
      0:       begin r.out = out16;         r.cout = c16; r.ovf = f16; r.zero = z16; end
      1:       begin r.out = {12'h0, out_p}; r.cout = c_p; r.ovf = f_p; r.zero = z_p; end
      default: begin r.out = {12'h0, out_s}; r.cout = c_s; r.ovf = f_s; r.zero = z_s; end
    endcase
    return r;
  endfunction

  function automatic logic get_ov(int idx);
    return (idx == 0) ? ov16 : (idx == 1) ? ov_p : ov_s;
  endfunction

  function automatic logic get_ir(int idx);
    return (idx == 0) ? ir16 : (idx == 1) ? ir_p : ir_s;
  endfunction

  task automatic drive_in(int idx, logic v, logic [15:0] a, logic [15:0] b, logic m);
    case (idx)
      0:       begin iv16 = v; a16 = a;      b16 = b;      m16 = m; end
      1:       begin iv_p = v; a_p = a[3:0]; b_p = b[3:0]; m_p = m; end
      default: begin iv_s = v; a_s = a[3:0]; b_s = b[3:0]; m_s = m; end
    endcase
  endtask

  task automatic set_ready(int idx, logic v);
    case (idx)
      0:       or16 = v;
      1:       or_p = v;
      default: or_s = v;
    endcase
  endtask

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_res(string tag, res_t act, res_t exp);
    check_output({tag, " out"},  32'(act.out), 32'(exp.out));
    check_output({tag, " Cout"}, 32'(act.cout), 32'(exp.cout));
    check_output({tag, " ovf"},  32'(act.ovf), 32'(exp.ovf));
    check_output({tag, " zero"}, 32'(act.zero), 32'(exp.zero));
  endtask

  // One full transaction; 'hold' cycles of out_ready=0 with in_valid toggling before release.
  task automatic apply_stimulus(int idx, logic [15:0] a, logic [15:0] b, logic m, res_t e,
                                int lat, int hold, string tag);
    int n;
    res_t got;
    @(negedge clk);
    drive_in(idx, 1'b1, a, b, m);
    check_output({tag, " in_ready"}, 32'(get_ir(idx)), 32'd1);
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    drive_in(idx, 1'b0, ~a, ~b, ~m);
    n = 0;
    while (!get_ov(idx) && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_output({tag, " latency"}, 32'(n), 32'(lat));
    got = sample(idx);
    if (sb.size() > 0) check_res(tag, got, sb.pop_front());
    for (int i = 0; i < hold; i++) begin
      drive_in(idx, i[0] ? 1'b0 : 1'b1, 16'($urandom), 16'($urandom), i[1]);
      @(posedge clk);
      @(negedge clk);
      got = sample(idx);
      check_output({tag, " hold stable"},
                   {get_ov(idx), get_ir(idx), got.zero, got.ovf, got.cout, 11'h0, got.out},
                   {1'b1, 1'b0, e.zero, e.ovf, e.cout, 11'h0, e.out});
    end
    drive_in(idx, 1'b0, a, b, m);
    set_ready(idx, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ready(idx, 1'b0);
    check_output({tag, " ov/ir after accept"}, {30'h0, get_ov(idx), get_ir(idx)}, 32'b01);
  endtask

  initial begin
    res_t zr;
    zr = '{out: 16'h0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
    tbl[2] = '{16'h0007, 16'h0005, 1'b1, '{16'h0002, 1'b1, 1'b0, 1'b0}};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};
`ifdef SEQ_ADDSUB_SATURATE_EN
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0}};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, '{16'h8000, 1'b1, 1'b1, 1'b0}};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0}};
`else
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1}};
`endif

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_in(i, 1'b0, 16'h0, 16'h0, 1'b0);
      set_ready(i, 1'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_res("reset", sample(0), zr);
    check_output("reset ov/ir", {30'h0, ov16, ir16}, 32'b01);
    check_output("reset small ir", {30'h0, ir_p, ir_s}, 32'b11);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      apply_stimulus(0, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].exp, 4, 0, $sformatf("vec%0d", i));

    apply_stimulus(0, tbl[4].a, tbl[4].b, tbl[4].m, tbl[4].exp, 4, 10, "hold");

    // Abort an operation with reset just as slice 2 would be computed.
    @(negedge clk);
    drive_in(0, 1'b1, 16'h1234, 16'h0FFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_res("abort", sample(0), zr);
    check_output("abort ov/ir", {30'h0, ov16, ir16}, 32'b01);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("abort no valid", 32'(ov16), 32'd0);
    end
    apply_stimulus(0, tbl[1].a, tbl[1].b, tbl[1].m, tbl[1].exp, 4, 0, "post-abort");

    for (int idx = 1; idx < 3; idx++)
      for (int m = 0; m < 2; m++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            apply_stimulus(idx, 16'(a), 16'(b), m[0], model(4, 16'(a), 16'(b), m[0]),
                           (idx == 1) ? 1 : 4, 0, (idx == 1) ? "sweep c4" : "sweep c1");

    check_output("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
